// File: rtl/eject_inject_stage.sv
// MinBD eject/inject stage feeding the permutation deflection network.
// Define FLIT_STATS_EN to add saturating ej_count/inj_count outputs.
module eject_inject_stage #(
  parameter int X_COORD   = 0,
  parameter int Y_COORD   = 0,
  parameter int INJ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] north_in,
  input  logic [10:0] east_in,
  input  logic [10:0] south_in,
  input  logic [10:0] west_in,
  output logic [10:0] north_out,
  output logic [10:0] east_out,
  output logic [10:0] south_out,
  output logic [10:0] west_out,
  input  logic [10:0] inj_flit,
  input  logic        inj_valid,
  output logic        inj_ready,
  output logic [10:0] ej_flit,
  output logic        ej_valid,
  input  logic        ej_ready
`ifdef FLIT_STATS_EN
  ,
  output logic [15:0] ej_count,
  output logic [15:0] inj_count
`endif
);

  localparam int AW = (INJ_DEPTH > 1) ? $clog2(INJ_DEPTH) : 1;
  localparam logic [AW:0] DEPTH = (AW+1)'(INJ_DEPTH);
  localparam logic [1:0] XC = 2'(X_COORD);
  localparam logic [1:0] YC = 2'(Y_COORD);

  logic [3:0][10:0] w_in;
  logic [3:0][10:0] r_in;
  logic [3:0][10:0] w_slot;
  logic [3:0][10:0] r_out;
  logic [3:0]       w_local;
  logic [3:0]       w_free;
  logic [1:0]       r_rr;
  logic [1:0]       w_win;
  logic [1:0]       w_sel;
  logic             w_ej;
  logic             w_inj;
  logic             w_push;
  logic [10:0]      r_mem [INJ_DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [AW:0]      r_cnt;
  logic [10:0]      r_ej_flit;
  logic             r_ej_valid;

  assign w_in = {west_in, south_in, east_in, north_in};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_local[i] = r_in[i][10]
                && (r_in[i][9:8] == XC)
                && (r_in[i][7:6] == YC);
    end
  end

  // Round-robin search starts at r_rr and wraps N,E,S,W.
  always_comb begin : ej_arb
    logic [1:0] idx;
    w_ej  = 1'b0;
    w_win = r_rr;
    idx   = r_rr;
    for (int k = 0; k < 4; k++) begin
      idx = r_rr + 2'(k);
      if (ej_ready && !w_ej && w_local[idx]) begin
        w_ej  = 1'b1;
        w_win = idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (r_in[i][10] && !(w_ej && (w_win == 2'(i))))
        w_slot[i] = r_in[i];
      else
        w_slot[i] = '0;
      w_free[i] = !w_slot[i][10];
    end
  end

  always_comb begin
    w_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_free[i]) w_sel = 2'(i);
    end
  end

  assign w_inj     = (r_cnt != '0) && (|w_free);
  assign inj_ready = (r_cnt != DEPTH);
  assign w_push    = inj_valid && inj_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in       <= '0;
      r_out      <= '0;
      r_ej_flit  <= '0;
      r_ej_valid <= 1'b0;
      r_rr       <= 2'd0;
    end else begin
      r_in <= w_in;
      for (int i = 0; i < 4; i++) begin
        if (w_inj && (w_sel == 2'(i)))
          r_out[i] <= r_mem[r_rd];
        else
          r_out[i] <= w_slot[i];
      end
      r_ej_valid <= w_ej;
      if (w_ej) begin
        r_ej_flit <= r_in[w_win];
        r_rr      <= w_win + 2'd1;
      end
    end
  end

  // Valid bit is forced at push time so stored entries inject as-is.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= inj_flit | 11'h400;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_inj)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_inj})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef FLIT_STATS_EN
  logic [15:0] r_ej_cnt;
  logic [15:0] r_inj_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ej_cnt  <= '0;
      r_inj_cnt <= '0;
    end else begin
      if (w_ej && (r_ej_cnt != 16'hFFFF))
        r_ej_cnt <= r_ej_cnt + 16'd1;
      if (w_inj && (r_inj_cnt != 16'hFFFF))
        r_inj_cnt <= r_inj_cnt + 16'd1;
    end
  end

  assign ej_count  = r_ej_cnt;
  assign inj_count = r_inj_cnt;
`endif

  assign north_out = r_out[0];
  assign east_out  = r_out[1];
  assign south_out = r_out[2];
  assign west_out  = r_out[3];
  assign ej_flit   = r_ej_flit;
  assign ej_valid  = r_ej_valid;

endmodule

// File: tb/tb_eject_inject_stage.sv
// Directed bench for eject_inject_stage with a queue-based reference model.
// Node sits at (2,2) so that 11'h681..11'h684 are local and 11'h415 is not.
module tb_eject_inject_stage;

  localparam int XC = 2;
  localparam int YC = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] n_i = '0, e_i = '0, s_i = '0, w_i = '0;
  logic [10:0] n_o, e_o, s_o, w_o;
  logic [10:0] inj_flit = '0;
  logic        inj_valid = 1'b0;
  logic        inj_ready;
  logic [10:0] ej_flit;
  logic        ej_valid;
  logic        ej_ready = 1'b0;
`ifdef FLIT_STATS_EN
  logic [15:0] ej_count, inj_count;
`endif

  int passed = 0;
  int total  = 0;

  eject_inject_stage #(
    .X_COORD(XC), .Y_COORD(YC), .INJ_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .north_in(n_i), .east_in(e_i),
    .south_in(s_i), .west_in(w_i),
    .north_out(n_o), .east_out(e_o),
    .south_out(s_o), .west_out(w_o),
    .inj_flit(inj_flit), .inj_valid(inj_valid),
    .inj_ready(inj_ready),
    .ej_flit(ej_flit), .ej_valid(ej_valid),
    .ej_ready(ej_ready)
`ifdef FLIT_STATS_EN
    , .ej_count(ej_count), .inj_count(inj_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [10:0] act,
                     input logic [10:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %h expected %h",
                  name, $time, act, exp);
  endtask

  function automatic bit is_local(input logic [10:0] f);
    return f[10] && (f[9:8] == 2'(XC)) && (f[7:6] == 2'(YC));
  endfunction

  // Reference model: stage-1 copy of the links, a queue for the FIFO.
  logic [10:0] m_in [4];
  logic [10:0] x_out [4];
  logic        x_ejv = 1'b0;
  logic [10:0] x_ejf = '0;
  int          m_rr = 0;
  logic [10:0] m_q [$];

  always @(posedge clk or negedge rst_n) begin : model
    logic [10:0] s [4];
    bit ej, injd, can_push;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_in[i]  = '0;
        x_out[i] = '0;
      end
      x_ejv = 1'b0;
      x_ejf = '0;
      m_rr  = 0;
      m_q.delete();
    end else begin
      can_push = (m_q.size() < DEPTH);
      for (int i = 0; i < 4; i++) s[i] = m_in[i][10] ? m_in[i] : 11'h000;
      ej = 0;
      if (ej_ready) begin
        for (int k = 0; k < 4; k++) begin
          int p;
          p = (m_rr + k) % 4;
          if (!ej && is_local(s[p])) begin
            ej    = 1;
            x_ejf = s[p];
            s[p]  = 11'h000;
            m_rr  = (p + 1) % 4;
          end
        end
      end
      x_ejv = ej;
      injd = 0;
      if (m_q.size() > 0) begin
        for (int i = 0; i < 4; i++) begin
          if (!injd && !s[i][10]) begin
            s[i] = m_q.pop_front() | 11'h400;
            injd = 1;
          end
        end
      end
      for (int i = 0; i < 4; i++) x_out[i] = s[i];
      if (inj_valid && can_push) m_q.push_back(inj_flit & 11'h3FF);
      m_in[0] = n_i; m_in[1] = e_i; m_in[2] = s_i; m_in[3] = w_i;
    end
  end

  always @(negedge clk) begin
    chk("north_out", n_o, x_out[0]);
    chk("east_out",  e_o, x_out[1]);
    chk("south_out", s_o, x_out[2]);
    chk("west_out",  w_o, x_out[3]);
    chk("ej_valid",  {10'b0, ej_valid}, {10'b0, x_ejv});
    chk("ej_flit",   ej_flit, x_ejf);
    chk("inj_ready", {10'b0, inj_ready},
        {10'b0, (m_q.size() != DEPTH)});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic links(input logic [10:0] n, e, s, w);
    n_i = n; e_i = e; s_i = s; w_i = w;
  endtask

  initial begin
    // Reset with everything asserted: nothing may be pushed.
    links(11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF);
    inj_flit = 11'h7FF; inj_valid = 1'b1; ej_ready = 1'b1;
    cyc(3);
    chk("rst_north", n_o, 11'h000);
    chk("rst_ejv", {10'b0, ej_valid}, 11'h000);
    chk("rst_ready", {10'b0, inj_ready}, 11'h001);
    links('0, '0, '0, '0);
    inj_valid = 1'b0; ej_ready = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    chk("post_rst_north", n_o, 11'h000);

    // Pass-through of a non-local flit.
    n_i = 11'h415;
    cyc(1);
    n_i = '0;
    cyc(1);
    chk("pt_north", n_o, 11'h415);
    chk("pt_east", e_o, 11'h000);
    chk("pt_ejv", {10'b0, ej_valid}, 11'h000);
    cyc(2);

    // Round-robin ejection: N first, then E.
    ej_ready = 1'b1;
    links(11'h681, 11'h681, '0, '0);
    cyc(1);
    cyc(1);
    links('0, '0, '0, '0);
    chk("rr1_ejf", ej_flit, 11'h681);
    chk("rr1_ejv", {10'b0, ej_valid}, 11'h001);
    chk("rr1_north", n_o, 11'h000);
    chk("rr1_east", e_o, 11'h681);
    cyc(1);
    chk("rr2_east", e_o, 11'h000);
    chk("rr2_north", n_o, 11'h681);
    chk("rr2_ejv", {10'b0, ej_valid}, 11'h001);
    cyc(2);
    chk("rr_hold_ejf", ej_flit, 11'h681);

    // Injection waits for a free slot.
    links(11'h415, 11'h415, 11'h415, 11'h415);
    inj_flit = 11'h02A; inj_valid = 1'b1;
    cyc(1);
    inj_valid = 1'b0;
    w_i = '0;
    cyc(1);
    chk("inj_blocked_west", w_o, 11'h415);
    cyc(1);
    chk("inj_west", w_o, 11'h42A);
    chk("inj_north", n_o, 11'h415);
    links('0, '0, '0, '0);
    cyc(3);

    // Fill the FIFO while links are saturated.
    links(11'h415, 11'h415, 11'h415, 11'h415);
    for (int i = 1; i <= 4; i++) begin
      inj_flit = 11'(i); inj_valid = 1'b1;
      cyc(1);
    end
    chk("full_ready", {10'b0, inj_ready}, 11'h000);
    inj_flit = 11'h005;
    cyc(1);
    chk("full_ready2", {10'b0, inj_ready}, 11'h000);
    inj_valid = 1'b0;
    links('0, '0, '0, '0);
    cyc(2);
    chk("drain1", n_o, 11'h401);
    chk("drain_ready", {10'b0, inj_ready}, 11'h001);
    chk("drain1_east", e_o, 11'h000);
    for (int i = 2; i <= 4; i++) begin
      cyc(1);
      chk("drain_n", n_o, 11'h400 | 11'(i));
    end
    cyc(1);
    chk("drain_5th_dropped", n_o, 11'h000);
    cyc(2);

    // Backpressure: local flit deflected, pointer left at S.
    ej_ready = 1'b0;
    s_i = 11'h681;
    cyc(1);
    s_i = '0;
    cyc(1);
    chk("bp_south", s_o, 11'h681);
    chk("bp_ejv", {10'b0, ej_valid}, 11'h000);
    ej_ready = 1'b1;
    links(11'h681, 11'h682, 11'h683, 11'h684);
    cyc(1);
    links('0, '0, '0, '0);
    cyc(1);
    chk("bp_rr_ejf", ej_flit, 11'h683);
    chk("bp_rr_south", s_o, 11'h000);
    chk("bp_rr_west", w_o, 11'h684);
    cyc(3);

    // Reset mid-operation drops queued flits.
    links(11'h415, 11'h415, 11'h415, 11'h415);
    inj_flit = 11'h011; inj_valid = 1'b1;
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk("midrst_north", n_o, 11'h000);
    chk("midrst_ready", {10'b0, inj_ready}, 11'h001);
    links('0, '0, '0, '0);
    inj_valid = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    chk("midrst_no_inj", n_o, 11'h000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
